// File: rtl/freq_sel_pkg.sv
// Shared definitions for the frequency-selection divider.
// Holds the selection width, the default divider parameters and the
// half-period helper used by both the divider and its bench model.
package freq_sel_pkg;

  localparam int SEL_W             = 3;
  localparam int DEFAULT_BASE_HALF = 2;
  localparam int DEFAULT_CNT_W     = 16;

  // Half-period length in enabled cycles for a given selection.
  // Selection 7 is the fastest (base_half); each step down doubles it.
  function automatic int unsigned half_len(input logic [SEL_W-1:0] sel,
                                           input int unsigned base_half);
    int unsigned shamt;
    shamt = 32'd7 - 32'(sel);
    return base_half << shamt;
  endfunction

endpackage

// File: rtl/freq_sel_divider.sv
// Programmable square-wave generator.
// Turns the 3-bit frequency selection into a 50 % duty clock and a
// once-per-period strobe. A new selection is only taken at the end of a
// full output period, so clk_out never produces a short or long pulse.
//
// Ports:
//   clk_nx     in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   enable     in   count enable; low freezes the block (tick forced low)
//   frec_num   in   requested selection, sampled only on full-period boundaries
//   clk_out    out  generated square wave
//   tick       out  one-cycle pulse in the cycle clk_out falls
//   sel_active out  selection currently in effect
module freq_sel_divider
  import freq_sel_pkg::*;
#(
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int BASE_HALF = DEFAULT_BASE_HALF
) (
  input  logic             clk_nx,
  input  logic             rst,
  input  logic             enable,
  input  logic [SEL_W-1:0] frec_num,
  output logic             clk_out,
  output logic             tick,
  output logic [SEL_W-1:0] sel_active
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic             at_last;

  // Terminal count for the half-period currently in effect. Depends only
  // on registered state, so no input reaches an output combinationally.
  always_comb begin
    cnt_last = CNT_W'(half_len(sel_active, BASE_HALF) - 32'd1);
    at_last  = (cnt == cnt_last);
  end

  // Half-period counter and output generation. The rising edge of
  // clk_out marks mid-period; the falling edge is the full-period
  // boundary, where tick fires and the next selection is latched.
  always_ff @(posedge clk_nx) begin
    if (rst) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      sel_active <= '0;
    end else if (!enable) begin
      tick <= 1'b0;
    end else if (!at_last) begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end else if (!clk_out) begin
      cnt     <= '0;
      clk_out <= 1'b1;
      tick    <= 1'b0;
    end else begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b1;
      sel_active <= frec_num;
    end
  end

endmodule

// File: tb/tb_freq_sel_divider.sv
// Directed self-checking bench for freq_sel_divider with default
// parameters (BASE_HALF = 2, CNT_W = 16). Expected cycle counts are
// hand-derived from the half-period table (sel 7 -> 2 ... sel 0 -> 256).
module tb_freq_sel_divider;

  logic       clk_nx;
  logic       rst;
  logic       enable;
  logic [2:0] frec_num;
  logic       clk_out;
  logic       tick;
  logic [2:0] sel_active;

  int checkCount;
  int passCount;
  int cyc;

  freq_sel_divider dut (
    .clk_nx     (clk_nx),
    .rst        (rst),
    .enable     (enable),
    .frec_num   (frec_num),
    .clk_out    (clk_out),
    .tick       (tick),
    .sel_active (sel_active)
  );

  // 10 ns system clock
  initial clk_nx = 1'b0;
  always #5 clk_nx = ~clk_nx;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance n clock edges; outputs are sampled and inputs driven 1 ns after the edge
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_nx);
      #1;
    end
  endtask

  // Edges until clk_out goes high (called while it is low); -1 on timeout
  task automatic waitRise(output int cycles);
    cycles = 0;
    do begin
      applyStimulus(1);
      cycles++;
    end while (clk_out != 1'b1 && cycles < 2000);
    if (clk_out != 1'b1) cycles = -1;
  endtask

  // Edges until tick is seen high; -1 on timeout
  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      applyStimulus(1);
      cycles++;
    end while (tick != 1'b1 && cycles < 2000);
    if (tick != 1'b1) cycles = -1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    frec_num = 3'd0;
    applyStimulus(2);
    checkOutput("reset_clk_out", int'(clk_out), 0);
    checkOutput("reset_tick", int'(tick), 0);
    checkOutput("reset_sel", int'(sel_active), 0);

    // Scenario 1: first period runs at sel 0, then sel 7 takes over
    rst      = 1'b0;
    enable   = 1'b1;
    frec_num = 3'd7;
    waitRise(cyc);
    checkOutput("s1_first_rise", cyc, 256);
    checkOutput("s1_tick_low_at_rise", int'(tick), 0);
    waitTick(cyc);
    checkOutput("s1_first_tick", cyc, 256);
    checkOutput("s1_clk_fall_with_tick", int'(clk_out), 0);
    checkOutput("s1_sel_loaded", int'(sel_active), 7);
    applyStimulus(1);
    checkOutput("s1_tick_one_cycle", int'(tick), 0);
    waitRise(cyc);
    checkOutput("s1_fast_rise", cyc, 1);
    waitTick(cyc);
    checkOutput("s1_fast_tick", cyc, 2);

    // Scenario 2: request 6 one cycle after a tick; applies at the next tick
    applyStimulus(1);
    frec_num = 3'd6;
    checkOutput("s2_sel_still_7", int'(sel_active), 7);
    waitTick(cyc);
    checkOutput("s2_remaining_period", cyc, 3);
    checkOutput("s2_sel_6", int'(sel_active), 6);
    frec_num = 3'd5;
    waitRise(cyc);
    checkOutput("s2_half_sel6", cyc, 4);
    waitTick(cyc);
    checkOutput("s2_second_half_sel6", cyc, 4);
    checkOutput("s2_sel_5", int'(sel_active), 5);

    // Scenario 3: freeze for 10 cycles mid-half-period at sel 5
    applyStimulus(3);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("s3_frozen_clk_%0d", i), int'(clk_out), 0);
      checkOutput($sformatf("s3_frozen_tick_%0d", i), int'(tick), 0);
    end
    enable = 1'b1;
    waitRise(cyc);
    checkOutput("s3_resume_rise", cyc, 5);
    checkOutput("s3_stretched_half", 3 + 10 + cyc, 18);
    frec_num = 3'd7;
    waitTick(cyc);
    checkOutput("s3_next_half", cyc, 8);
    checkOutput("s3_sel_7", int'(sel_active), 7);

    // Scenario 5: 3 -> 5 -> 3 glitch within one sel-7 period
    applyStimulus(1);
    frec_num = 3'd3;
    applyStimulus(1);
    checkOutput("s5_mid_rise", int'(clk_out), 1);
    frec_num = 3'd5;
    applyStimulus(1);
    frec_num = 3'd3;
    waitTick(cyc);
    checkOutput("s5_boundary", cyc, 1);
    checkOutput("s5_sel_3", int'(sel_active), 3);
    waitRise(cyc);
    checkOutput("s5_half_sel3", cyc, 32);
    waitTick(cyc);
    checkOutput("s5_second_half_sel3", cyc, 32);
    checkOutput("s5_sel_still_3", int'(sel_active), 3);

    // Scenario 6: enable drops exactly on a full-period boundary cycle
    waitRise(cyc);
    checkOutput("s6_rise", cyc, 32);
    applyStimulus(31);
    checkOutput("s6_pre_boundary_clk", int'(clk_out), 1);
    checkOutput("s6_pre_boundary_tick", int'(tick), 0);
    enable   = 1'b0;
    frec_num = 3'd4;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("s6_gap_clk_%0d", i), int'(clk_out), 1);
      checkOutput($sformatf("s6_gap_tick_%0d", i), int'(tick), 0);
      checkOutput($sformatf("s6_gap_sel_%0d", i), int'(sel_active), 3);
    end
    enable = 1'b1;
    applyStimulus(1);
    checkOutput("s6_deferred_fall", int'(clk_out), 0);
    checkOutput("s6_deferred_tick", int'(tick), 1);
    checkOutput("s6_deferred_sel", int'(sel_active), 4);

    // Scenario 4: reset mid-period at sel 3, then restart like scenario 1
    frec_num = 3'd3;
    waitTick(cyc);
    checkOutput("s4_period_sel4", cyc, 32);
    checkOutput("s4_sel_3", int'(sel_active), 3);
    applyStimulus(10);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("s4_rst_clk", int'(clk_out), 0);
    checkOutput("s4_rst_tick", int'(tick), 0);
    checkOutput("s4_rst_sel", int'(sel_active), 0);
    rst      = 1'b0;
    frec_num = 3'd7;
    waitRise(cyc);
    checkOutput("s4_restart_rise", cyc, 256);
    waitTick(cyc);
    checkOutput("s4_restart_tick", cyc, 256);
    checkOutput("s4_restart_sel", int'(sel_active), 7);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/freq_sel_divider.md
# freq_sel_divider

Programmable square-wave generator driven by the 3-bit frequency selection produced by the push-button up/down counter. It turns the selection `frec_num` into an output clock `clk_out` and a once-per-period `tick` strobe. Selection changes are applied only at full-period boundaries, so `clk_out` never glitches. It sits directly downstream of the selection counter, on the same `clk_nx` domain.

## Interface
- `CNT_W`, default 16: width of the internal half-period counter. Must satisfy `BASE_HALF << 7 <= 2**CNT_W`.
- `BASE_HALF`, default 2: half-period length, in enabled cycles, for the fastest selection (7). Must be ≥ 1.

Ports:
- `clk_nx`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  count enable; when low, the block freezes.
- `frec_num`  in  3  requested frequency selection from the up/down counter.
- `clk_out`  out  1  generated square wave, 50 % duty.
- `tick`  out  1  one-cycle pulse at the end of each full `clk_out` period.
- `sel_active`  out  3  selection currently in effect.

## Operation
- Half-period length is `half_len(s) = BASE_HALF << (7 - s)`.
  - s = 7 is the fastest setting; s = 0 is the slowest.
  - With the defaults, `half_len` ranges from 2 (s = 7) to 256 (s = 0).
- Registered state: `cnt[CNT_W-1:0]`, `clk_out`, `tick`, `sel_active`.
- Reset has priority over everything and clears all state:
  - `cnt`=0, `clk_out`=0, `tick`=0, `sel_active`=0.
- With `enable`=0 and `rst`=0:
  - `cnt`, `clk_out` and `sel_active` hold.
  - `tick` is forced to 0.
- With `enable`=1, each cycle behaves as follows:
  - If `cnt != half_len(sel_active)-1`: `cnt` increments and `tick`=0.
  - Else, if `clk_out`=0 (mid-period boundary): `cnt`=0, `clk_out`=1, `tick`=0.
  - Else (full-period boundary): `cnt`=0, `clk_out`=0, `tick`=1, and `sel_active` loads `frec_num` as sampled in that cycle.
- Only the value of `frec_num` in a full-period boundary cycle matters. Changes at any other time are ignored.
- `frec_num` wraps 7→0 and 0→7 upstream. No special handling here; the wrap takes effect at the next boundary like any other change.

## Timing
- `clk_out` period is exactly `2*half_len(sel_active)` enabled cycles. Disabled cycles stretch the period 1:1.
- `tick` rises in the same cycle that `clk_out` falls and lasts exactly one cycle. It is never asserted while `enable`=0.
- After reset, the first period uses sel 0: `clk_out` rises after `half_len(0)` enabled cycles.
- Latency of a selection change is one to two periods:
  - The new value must be present on a full-period boundary cycle.
  - The new half length applies starting the cycle after the `tick` rises.
- If `enable` is low in the cycle that would be a boundary, the boundary is deferred to the next enabled cycle. No state is lost.
- Reset asserted mid-period: the next cycle shows reset values, regardless of `enable`.
- No combinational path from any input to any output.

## Structure
- Shared package `freq_sel_pkg` holds:
  - `SEL_W` = 3;
  - default `BASE_HALF` and `CNT_W`;
  - function `half_len(sel)`, also reused by the bench model.
- No sub-module. One sequential process plus the package function; the `half_len` compare is combinational on `sel_active`.

## Test plan
All scenarios use the defaults (`BASE_HALF`=2, `CNT_W`=16).

1. Reset, then `frec_num`=7 and `enable`=1 held:
   - `clk_out` rises at enabled cycle 256 and falls at 512 with `tick`=1 and `sel_active`=7.
   - Thereafter `clk_out` toggles every 2 cycles and `tick` fires every 4.
2. With `sel_active`=7 running, change `frec_num` to 6 one cycle after a `tick`:
   - Period stays 4 until the next `tick`, which loads 6.
   - Period then becomes 8, with no short or long pulse.
3. Drop `enable` for 10 cycles mid-half-period at sel 5 (half 8):
   - `clk_out` and `cnt` freeze and `tick` stays 0.
   - That half-period lasts 18 cycles; the next half is 8 again.
4. Assert `rst` for 1 cycle mid-period at sel 3 with `enable`=1:
   - Next cycle shows `clk_out`=0, `tick`=0, `sel_active`=0, `cnt`=0.
   - Restart timing then matches scenario 1.
5. At sel 7, pulse `frec_num` 3→5→3 within one period so that it is 3 on the boundary cycle:
   - `sel_active` becomes 3 and half-period becomes 32; value 5 is never applied.
6. Deassert `enable` exactly on a full-period boundary cycle for 3 cycles:
   - No `tick` and no `clk_out` fall during the gap.
   - The fall, `tick` and selection load occur on the first cycle after `enable` returns high.
